universal_shift_register: RTL and testbench
===========================================

// Module: universal_shift_register
// PURPOSE
//   Parametrised successor of the 4-bit serial shift register: WIDTH-bit register with
//   shift enable, left/right shift, rotate, arithmetic shift, parallel load and a
//   shift counter that flags a completed word. Used as the generic SIPO/PISO/rotator
//   stage in datapath and serial-link blocks.
// PARAMETERS
//   WIDTH        8    register width in bits; legal range WIDTH >= 2
//   RESET_VALUE  0    value loaded into the register on reset (WIDTH bits)
// PORTS
//   clk         in   1                  rising-edge clock
//   reset       in   1                  synchronous, active-high reset
//   en          in   1                  operation enable; 0 = hold everything
//   mode        in   3                  operation select (see BEHAVIOUR)
//   in          in   1                  serial input bit
//   load_data   in   WIDTH              parallel load word
//   out         out  WIDTH              register contents
//   msb_out     out  1                  out[WIDTH-1] (bit leaving on left shift)
//   lsb_out     out  1                  out[0] (bit leaving on right shift)
//   shift_count out  $clog2(WIDTH+1)    shifts since last reset/load, saturates at WIDTH
//   word_done   out  1                  one-cycle pulse when shift_count reaches WIDTH
// BEHAVIOUR
//   - All state updates on rising clk; outputs are registered or direct register taps.
//   - reset=1: out<=RESET_VALUE, shift_count<=0, word_done<=0; reset overrides en/mode.
//     Reset mid-word abandons the word; no word_done is produced for it.
//   - en=0: out, shift_count held; word_done<=0.
//   - en=1, mode decode (r = current out):
//       000 hold        r unchanged, count unchanged
//       001 shr         r <= {in, r[WIDTH-1:1]}
//       010 shl         r <= {r[WIDTH-2:0], in}
//       011 ror         r <= {r[0], r[WIDTH-1:1]}        (in ignored)
//       100 rol         r <= {r[WIDTH-2:0], r[WIDTH-1]}  (in ignored)
//       101 load        r <= load_data, shift_count <= 0
//       110 asr         r <= {r[WIDTH-1], r[WIDTH-1:1]}  (in ignored)
//       111 reserved    treated as hold
//   - Modes 001,010,011,100,110 are "shift ops": shift_count <= min(count+1, WIDTH).
//   - word_done <= 1 exactly on the edge where count goes WIDTH-1 -> WIDTH; 0 otherwise.
//     Further shifts at count==WIDTH: count stays WIDTH, word_done stays 0.
//   - Load at count==WIDTH-1 clears count; no word_done. Latency of every op: 1 cycle.
//   - msb_out/lsb_out are combinational taps of out (0 cycles after out updates).
// CONFIGURATION
//   SHIFT_REG_PARITY_EN defined: extra output port  parity  out  1 , registered,
//     equal to ^out at all times (updated in the same edge as out; reset value
//     ^RESET_VALUE). Computed from next-state value, not one cycle late.
//   Undefined: no parity port, no parity logic; all other behaviour identical.
// TESTING (WIDTH=4, RESET_VALUE=0 unless stated)
//   1 reset=1 two cycles, any mode/en -> out=0000, shift_count=0, word_done=0.
//   2 en=1 mode=001, in=1,0,1,0 over 4 edges -> out 1000,0100,1010,0101; word_done
//     high only after 4th edge, shift_count=4; 5th shift -> count stays 4, no pulse.
//   3 mode=101 load_data=1001, then mode=100 x2 -> out 1001,0011,0110; lsb_out=0;
//     then mode=011 -> 0011; count after load sequence = 3.
//   4 load 1000, mode=110 x2 -> 1100,1110; en=0 for 3 cycles -> out held 1110,
//     word_done=0; mode=111 -> held.
//   5 shift 2 bits, assert reset with en=1 mode=010 -> next edge out=0000, count=0;
//     then 4 shl with in=1 -> 1111, word_done pulse once.
//   6 SHIFT_REG_PARITY_EN: load 0111 -> parity=1 same edge; shl in=1 -> 1111, parity=0.

Source files
------------

// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: shift/rotate/arithmetic shift, parallel load,
// saturating shift counter with word-complete pulse. Optional parity output via SHIFT_REG_PARITY_EN.
module universal_shift_register #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   mode,
  input  logic                         in,
  input  logic [WIDTH-1:0]             load_data,
  output logic [WIDTH-1:0]             out,
  output logic                         msb_out,
  output logic                         lsb_out,
  output logic [$clog2(WIDTH+1)-1:0]   shift_count,
`ifdef SHIFT_REG_PARITY_EN
  output logic                         parity,
`endif
  output logic                         word_done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_ROR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_LOAD = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_t;

  logic [WIDTH-1:0] next_reg;
  logic             is_shift;
  logic             is_load;

  always_comb begin
    next_reg = out;
    is_shift = 1'b0;
    is_load  = 1'b0;
    case (mode_t'(mode))
      MODE_SHR:  begin next_reg = {in, out[WIDTH-1:1]};         is_shift = 1'b1; end
      MODE_SHL:  begin next_reg = {out[WIDTH-2:0], in};         is_shift = 1'b1; end
      MODE_ROR:  begin next_reg = {out[0], out[WIDTH-1:1]};     is_shift = 1'b1; end
      MODE_ROL:  begin next_reg = {out[WIDTH-2:0], out[WIDTH-1]}; is_shift = 1'b1; end
      MODE_ASR:  begin next_reg = {out[WIDTH-1], out[WIDTH-1:1]}; is_shift = 1'b1; end
      MODE_LOAD: begin next_reg = load_data;                    is_load  = 1'b1; end
      default:   next_reg = out;
    endcase
  end

  // word_done fires only on the WIDTH-1 -> WIDTH transition; the count then saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      out         <= RESET_VALUE;
      shift_count <= '0;
      word_done   <= 1'b0;
    end else if (en) begin
      out       <= next_reg;
      word_done <= is_shift && (shift_count == FULL - 1'b1);
      if (is_load)
        shift_count <= '0;
      else if (is_shift && shift_count != FULL)
        shift_count <= shift_count + 1'b1;
    end else begin
      word_done <= 1'b0;
    end
  end

`ifdef SHIFT_REG_PARITY_EN
  // parity tracks the next-state value so it changes on the same edge as out
  always_ff @(posedge clk) begin
    if (reset)
      parity <= ^RESET_VALUE;
    else if (en)
      parity <= ^next_reg;
  end
`endif

  assign msb_out = out[WIDTH-1];
  assign lsb_out = out[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register at WIDTH=4, RESET_VALUE=0.
module tb_universal_shift_register;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic       in;
  logic [3:0] load_data;
  logic [3:0] out;
  logic       msb_out;
  logic       lsb_out;
  logic [2:0] shift_count;
  logic       word_done;
`ifdef SHIFT_REG_PARITY_EN
  logic       parity;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int donePulses;

  universal_shift_register #(.WIDTH(4), .RESET_VALUE(4'b0000)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .mode(mode),
    .in(in),
    .load_data(load_data),
    .out(out),
    .msb_out(msb_out),
    .lsb_out(lsb_out),
    .shift_count(shift_count),
`ifdef SHIFT_REG_PARITY_EN
    .parity(parity),
`endif
    .word_done(word_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // drive one operation, let one rising edge pass, then settle before sampling
  task automatic applyStimulus(input logic e, input logic [2:0] m, input logic i, input logic [3:0] ld);
    en = e;
    mode = m;
    in = i;
    load_data = ld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b1;
    mode = 3'b010;
    in = 1'b1;
    load_data = 4'b1111;

    // reset dominates en/mode
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_out", 32'(out), 32'h0);
    checkOutput("reset_count", 32'(shift_count), 32'd0);
    checkOutput("reset_done", 32'(word_done), 32'd0);
`ifdef SHIFT_REG_PARITY_EN
    checkOutput("reset_parity", 32'(parity), 32'd0);
`endif
    reset = 1'b0;

    // shift right, serial in 1,0,1,0
    applyStimulus(1'b1, 3'b001, 1'b1, 4'h0);
    checkOutput("shr1_out", 32'(out), 32'b1000);
    checkOutput("shr1_done", 32'(word_done), 32'd0);
    applyStimulus(1'b1, 3'b001, 1'b0, 4'h0);
    checkOutput("shr2_out", 32'(out), 32'b0100);
    applyStimulus(1'b1, 3'b001, 1'b1, 4'h0);
    checkOutput("shr3_out", 32'(out), 32'b1010);
    checkOutput("shr3_count", 32'(shift_count), 32'd3);
    checkOutput("shr3_done", 32'(word_done), 32'd0);
    applyStimulus(1'b1, 3'b001, 1'b0, 4'h0);
    checkOutput("shr4_out", 32'(out), 32'b0101);
    checkOutput("shr4_count", 32'(shift_count), 32'd4);
    checkOutput("shr4_done", 32'(word_done), 32'd1);
    checkOutput("shr4_lsb", 32'(lsb_out), 32'd1);
    applyStimulus(1'b1, 3'b001, 1'b0, 4'h0);
    checkOutput("shr5_out", 32'(out), 32'b0010);
    checkOutput("shr5_count", 32'(shift_count), 32'd4);
    checkOutput("shr5_done", 32'(word_done), 32'd0);

    // load then rotate left twice, rotate right once
    applyStimulus(1'b1, 3'b101, 1'b0, 4'b1001);
    checkOutput("load_out", 32'(out), 32'b1001);
    checkOutput("load_count", 32'(shift_count), 32'd0);
    checkOutput("load_msb", 32'(msb_out), 32'd1);
    applyStimulus(1'b1, 3'b100, 1'b1, 4'h0);
    checkOutput("rol1_out", 32'(out), 32'b0011);
    applyStimulus(1'b1, 3'b100, 1'b1, 4'h0);
    checkOutput("rol2_out", 32'(out), 32'b0110);
    checkOutput("rol2_lsb", 32'(lsb_out), 32'd0);
    checkOutput("rol2_msb", 32'(msb_out), 32'd0);
    applyStimulus(1'b1, 3'b011, 1'b1, 4'h0);
    checkOutput("ror_out", 32'(out), 32'b0011);
    checkOutput("ror_count", 32'(shift_count), 32'd3);

    // load at count WIDTH-1 clears count without a pulse
    applyStimulus(1'b1, 3'b101, 1'b0, 4'b1000);
    checkOutput("load3_out", 32'(out), 32'b1000);
    checkOutput("load3_count", 32'(shift_count), 32'd0);
    checkOutput("load3_done", 32'(word_done), 32'd0);

    // arithmetic shift right, then hold via en=0 and reserved mode
    applyStimulus(1'b1, 3'b110, 1'b0, 4'h0);
    checkOutput("asr1_out", 32'(out), 32'b1100);
    applyStimulus(1'b1, 3'b110, 1'b0, 4'h0);
    checkOutput("asr2_out", 32'(out), 32'b1110);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'b010, 1'b1, 4'h5);
      checkOutput("en0_out", 32'(out), 32'b1110);
      checkOutput("en0_done", 32'(word_done), 32'd0);
    end
    checkOutput("en0_count", 32'(shift_count), 32'd2);
    applyStimulus(1'b1, 3'b111, 1'b1, 4'h5);
    checkOutput("rsvd_out", 32'(out), 32'b1110);
    checkOutput("rsvd_count", 32'(shift_count), 32'd2);
    applyStimulus(1'b1, 3'b000, 1'b1, 4'h5);
    checkOutput("hold_out", 32'(out), 32'b1110);

    // reset mid-word abandons the word
    applyStimulus(1'b1, 3'b101, 1'b0, 4'b0000);
    applyStimulus(1'b1, 3'b010, 1'b1, 4'h0);
    applyStimulus(1'b1, 3'b010, 1'b1, 4'h0);
    checkOutput("pre_reset_out", 32'(out), 32'b0011);
    checkOutput("pre_reset_count", 32'(shift_count), 32'd2);
    reset = 1'b1;
    applyStimulus(1'b1, 3'b010, 1'b1, 4'h0);
    reset = 1'b0;
    checkOutput("midreset_out", 32'(out), 32'h0);
    checkOutput("midreset_count", 32'(shift_count), 32'd0);
    checkOutput("midreset_done", 32'(word_done), 32'd0);
    donePulses = 0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 3'b010, 1'b1, 4'h0);
      if (word_done) donePulses++;
    end
    checkOutput("shl4_out", 32'(out), 32'b1111);
    checkOutput("shl4_done", 32'(word_done), 32'd1);
    checkOutput("shl4_pulses", 32'(donePulses), 32'd1);
    applyStimulus(1'b0, 3'b010, 1'b1, 4'h0);
    checkOutput("done_clear_en0", 32'(word_done), 32'd0);
    checkOutput("done_clear_count", 32'(shift_count), 32'd4);

`ifdef SHIFT_REG_PARITY_EN
    applyStimulus(1'b1, 3'b101, 1'b0, 4'b0111);
    checkOutput("par_load", 32'(parity), 32'd1);
    applyStimulus(1'b1, 3'b010, 1'b1, 4'h0);
    checkOutput("par_shl_out", 32'(out), 32'b1111);
    checkOutput("par_shl", 32'(parity), 32'd0);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
